riscv_ifq: RTL and testbench

Instruction fetch queue sitting directly downstream of riscv_ifu and upstream of the decode stage.
- Accepts fetched {pc, instr, err} beats from the IFU, buffers them in a small FIFO and presents them to decode over a valid/ready handshake.
- Adds per-entry predecode flags.
- Supports a single-cycle flush on pipeline redirect.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_predecode.sv | 22 ++
 rtl/riscv_ifq.sv | 111 +++++++++++
 tb/tb_riscv_ifq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch/decode types: the fetch queue entry and the RV32 control-flow opcodes.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    err;
  } ifq_entry_t;

endpackage

// File: rtl/riscv_predecode.sv
// Combinational predecode of one fetched entry: control-flow detection and
// quick illegal screen (compressed encodings are treated as illegal).
module riscv_predecode
  import riscv_pkg::*;
(
  input  ifq_entry_t entry,
  output logic       is_branch,
  output logic       illegal
);

  logic [6:0] opcode;
  logic       unused_bits;

  always_comb begin
    opcode    = entry.instr[6:0];
    is_branch = (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    illegal   = (entry.instr[1:0] != 2'b11) || entry.err;
  end

  assign unused_bits = ^{entry.pc, entry.instr[XLEN_DEFAULT-1:7]};

endmodule

// File: rtl/riscv_ifq.sv
// Instruction fetch queue between IFU and decode with predecode flags and flush.
// Optional zero-latency empty-queue bypass when RISCV_IFQ_BYPASS_EN is defined.
module riscv_ifq
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instr,
  input  logic                   in_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr,
  output logic                   out_err,
  output logic                   out_is_branch,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic            err_mem_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;

  logic empty, full, push, pop, bypass;

  ifq_entry_t pd_entry;
  logic       pd_is_branch, pd_illegal;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // in_ready depends only on registered pointers; a pop never frees a slot in the same cycle.
  always_comb begin
    empty    = (rd_ptr_q == wr_ptr_q);
    full     = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    in_ready = !full;
    bypass   = 1'b0;
`ifdef RISCV_IFQ_BYPASS_EN
    bypass   = empty && in_valid && !flush;
`endif
    push     = in_valid && !full && !flush && !(bypass && out_ready);
    pop      = !empty && out_ready && !flush;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
    count    = wr_ptr_q - rd_ptr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_idx]    <= in_pc;
      instr_mem_q[wr_idx] <= in_instr;
      err_mem_q[wr_idx]   <= in_err;
    end
  end

  // Fields are forced to zero while nothing is presented so reset and empty look identical.
  always_comb begin
    out_valid = !empty || bypass;
    out_pc    = '0;
    out_instr = '0;
    out_err   = 1'b0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
      out_err   = in_err;
    end else if (!empty) begin
      out_pc    = pc_mem_q[rd_idx];
      out_instr = instr_mem_q[rd_idx];
      out_err   = err_mem_q[rd_idx];
    end
    pd_entry.pc    = XLEN_DEFAULT'(out_pc);
    pd_entry.instr = XLEN_DEFAULT'(out_instr);
    pd_entry.err   = out_err;
  end

  riscv_predecode u_predecode (
    .entry     (pd_entry),
    .is_branch (pd_is_branch),
    .illegal   (pd_illegal)
  );

  always_comb begin
    out_is_branch = out_valid && pd_is_branch;
    out_illegal   = out_valid && pd_illegal;
  end

endmodule

// File: tb/tb_riscv_ifq.sv
// Self-checking bench for riscv_ifq: directed vector table plus a queue scoreboard.
module tb_riscv_ifq;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, in_err;
  logic        out_valid, out_ready, out_err, out_is_branch, out_illegal;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]  count;

  riscv_ifq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_err(out_err), .out_is_branch(out_is_branch), .out_illegal(out_illegal), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } beat_t;

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] pc, instr;
    logic        err;
    int          exp_cnt;
    logic        exp_valid;
  } vec_t;

  beat_t q[$];
  vec_t  tbl[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic exp_branch(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc == 7'h63) || (opc == 7'h6F) || (opc == 7'h67);
  endfunction

  function automatic logic exp_illegal(input logic [31:0] instr, input logic err);
    return (instr[1:0] != 2'b11) || err;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] pc, input logic [31:0] instr, input logic err);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_pc     = pc;
    in_instr  = instr;
    in_err    = err;
  endtask

  task automatic add(input logic iv, input logic ordy, input logic fl,
                     input logic [31:0] pc, input logic [31:0] instr, input logic err,
                     input int c, input logic v);
    vec_t r;
    r.iv = iv; r.ordy = ordy; r.fl = fl; r.pc = pc; r.instr = instr; r.err = err;
    r.exp_cnt = c; r.exp_valid = v;
    tbl.push_back(r);
  endtask

  // Compare the DUT against the scoreboard, then advance one clock and update the model.
  task automatic sb_cycle();
    beat_t h, inb;
    logic  byp, ev, er, pushing, popping;
    int    sz;
    sz  = q.size();
    byp = 1'b0;
`ifdef RISCV_IFQ_BYPASS_EN
    byp = (sz == 0) && in_valid && !flush;
`endif
    ev = (sz != 0) || byp;
    er = (sz < DEPTH);
    inb.pc = in_pc; inb.instr = in_instr; inb.err = in_err;
    h = '0;
    if (byp) h = inb;
    else if (sz != 0) h = q[0];
    #1;
    chk("count", 32'(count), 32'(sz));
    chk("count_max", 32'(count <= 3'(DEPTH)), 32'd1);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("out_pc", out_pc, h.pc);
      chk("out_instr", out_instr, h.instr);
      chk("out_err", 32'(out_err), 32'(h.err));
      chk("out_is_branch", 32'(out_is_branch), 32'(exp_branch(h.instr)));
      chk("out_illegal", 32'(out_illegal), 32'(exp_illegal(h.instr, h.err)));
    end else begin
      chk("idle_is_branch", 32'(out_is_branch), 32'd0);
      chk("idle_illegal", 32'(out_illegal), 32'd0);
    end
    pushing = in_valid && er && !flush && !(byp && out_ready);
    popping = (sz != 0) && out_ready && !flush;
    if (flush) q.delete();
    else begin
      if (popping) void'(q.pop_front());
      if (pushing) q.push_back(inb);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [6:0]  opcs [5];
    logic [31:0] rnd_instr;
    opcs[0] = 7'h63; opcs[1] = 7'h6F; opcs[2] = 7'h67; opcs[3] = 7'h13; opcs[4] = 7'h01;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_is_branch", 32'(out_is_branch), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    //   iv ordy fl  pc          instr        err cnt valid
    add(1, 1, 0, 32'h0,    32'h0000_0013, 0, 0, 0);
    add(0, 1, 0, 32'h0,    32'h0,         0, 1, 1);
    add(0, 0, 0, 32'h0,    32'h0,         0, 0, 0);
    add(1, 0, 0, 32'h0,    32'h0000_0013, 0, 0, 0);
    add(1, 0, 0, 32'h4,    32'h0000_0093, 0, 1, 1);
    add(1, 0, 0, 32'h8,    32'h0000_0113, 0, 2, 1);
    add(1, 0, 0, 32'hC,    32'h0000_0193, 0, 3, 1);
    add(1, 0, 0, 32'h10,   32'h0000_0213, 0, 4, 1);
    add(1, 1, 0, 32'h14,   32'h0000_0293, 0, 4, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 3, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 2, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 1, 1);
    add(0, 0, 0, 32'h0,    32'h0,         0, 0, 0);
    add(1, 0, 0, 32'h40,   32'h0000_0013, 0, 0, 0);
    add(1, 0, 0, 32'h44,   32'h0000_0013, 0, 1, 1);
    add(1, 1, 1, 32'h100,  32'h0000_0013, 0, 2, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 0, 0);
    add(1, 0, 0, 32'h50,   32'h0000_006F, 0, 0, 0);
    add(1, 0, 0, 32'h54,   32'h0000_4501, 0, 1, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 2, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 1, 1);
    add(0, 0, 0, 32'h0,    32'h0,         0, 0, 0);
    add(1, 0, 0, 32'h20,   32'h0000_0013, 1, 0, 0);
    add(0, 1, 0, 32'h0,    32'h0,         0, 1, 1);
    add(0, 0, 0, 32'h0,    32'h0,         0, 0, 0);
    add(1, 1, 0, 32'h60,   32'h0000_0013, 0, 0, 0);
    add(1, 1, 0, 32'h64,   32'h0000_0063, 0, 1, 1);
    add(0, 1, 0, 32'h0,    32'h0,         0, 1, 1);
    add(0, 0, 0, 32'h0,    32'h0,         0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pc, tbl[i].instr, tbl[i].err);
`ifndef RISCV_IFQ_BYPASS_EN
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
`endif
      sb_cycle();
    end

    // Asynchronous reset with entries queued: everything clears without waiting for a clock.
    drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h0000_0013, 1'b0);
    sb_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h204, 32'h0000_006F, 1'b0);
    sb_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_illegal", 32'(out_illegal), 32'd0);
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;

    for (int c = 0; c < 1000; c++) begin
      rnd_instr = $urandom;
      rnd_instr[6:0] = opcs[$urandom_range(0, 4)];
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
            32'(c) << 2, rnd_instr, ($urandom_range(0, 15) == 0));
      sb_cycle();
    end

    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int c = 0; c < DEPTH + 1; c++) sb_cycle();
    chk("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
